// File: rtl/memsched_pkg.sv
// memsched shared types: FSM state encoding, requester indices, control strobes.
package memsched_pkg;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_ISSUE = 2'd1,
    MS_WAIT  = 2'd2,
    MS_DONE  = 2'd3
  } ms_state_e;

  localparam int MS_PROM   = 0;
  localparam int MS_CROM   = 1;
  localparam int MS_PRGRAM = 2;
  localparam int MS_CHRRAM = 3;

  typedef struct packed {
    logic lat;    // grant taken in IDLE, request fields latched
    logic hit;    // granted read served from the per-requester cache
    logic issue;  // raise extreq
    logic cap;    // external ack accepted
    logic tmo;    // watchdog expired
    logic fire;   // ack pulse to the granted requester
  } ms_ctl_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/memsched_if.sv
// memsched bus bundle: requester side (req/ack) plus the external memory port.
interface memsched_if #(
  parameter int N  = 4,
  parameter int AW = 22
);
  logic [N-1:0]    req;
  logic [N-1:0]    reqwr;
  logic [N*AW-1:0] reqaddr;
  logic [N*8-1:0]  reqwdata;
  logic [N-1:0]    ack;
  logic [7:0]      rdata;
  logic [AW-1:0]   extaddr;
  logic [7:0]      extwdata;
  logic            extwr;
  logic            extreq;
  logic            extack;
  logic [7:0]      extrdata;

  // slave: the scheduler; master: requesters plus external memory controller
  modport slave (
    input  req, reqwr, reqaddr, reqwdata, extack, extrdata,
    output ack, rdata, extaddr, extwdata, extwr, extreq
  );
  modport master (
    output req, reqwr, reqaddr, reqwdata, extack, extrdata,
    input  ack, rdata, extaddr, extwdata, extwr, extreq
  );
endinterface

// File: rtl/memsched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot + index.
module rr_pick
  import memsched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          any
);
  always_comb begin
    int j;
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    j    = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        gidx   = IW'(j);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/memsched.sv
// memsched: round-robin sharing of one external memory port, one transaction in flight.
// Optional MEMSCHED_CACHE_EN adds a one-entry read cache per requester.
module memsched
  import memsched_pkg::*;
#(
  parameter int N   = 4,
  parameter int AW  = 22,
  parameter int TMO = 255
) (
  input  logic       clk,
  input  logic       reset,
  memsched_if.slave  bus,
  output logic       tmoerr
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TMO + 1);

  ms_state_e     st, st_nx;
  ms_ctl_t       ctl;
  logic [IW-1:0] rr, idx, pidx;
  logic [N-1:0]  pgnt, lgnt, pend;
  logic          pany, hit, ack_ok;
  logic [WW-1:0] wd;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wd, hit_data;
  logic          sel_wr;

  // the requester being acked still holds req this cycle; keep it out of the pick
  assign pend     = bus.req & ~bus.ack;
  assign ack_ok   = bus.extack & bus.extreq;
  assign sel_addr = bus.reqaddr[int'(pidx)*AW +: AW];
  assign sel_wd   = bus.reqwdata[int'(pidx)*8 +: 8];
  assign sel_wr   = bus.reqwr[pidx];

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(pend), .ptr(rr), .gnt(pgnt), .gidx(pidx), .any(pany)
  );

`ifdef MEMSCHED_CACHE_EN
  logic [AW-1:0] c_addr [N];
  logic [7:0]    c_data [N];
  logic [N-1:0]  c_vld;

  assign hit      = !sel_wr && c_vld[pidx] && (c_addr[pidx] == sel_addr);
  assign hit_data = c_data[pidx];

  // any write may alias a cached line of another requester, so drop everything
  always_ff @(posedge clk) begin
    if (reset)                    c_vld      <= '0;
    else if (ctl.lat && sel_wr)   c_vld      <= '0;
    else if (ctl.cap && !bus.extwr) c_vld[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ctl.cap && !bus.extwr) begin
      c_addr[idx] <= bus.extaddr;
      c_data[idx] <= bus.extrdata;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) st <= MS_IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      MS_IDLE:  if (pany) st_nx = hit ? MS_DONE : MS_ISSUE;
      MS_ISSUE: st_nx = MS_WAIT;
      MS_WAIT:  if (ack_ok || wd == WW'(TMO)) st_nx = MS_DONE;
      MS_DONE:  st_nx = MS_IDLE;
      default:  st_nx = MS_IDLE;
    endcase
  end

  always_comb begin
    ctl       = '0;
    ctl.lat   = (st == MS_IDLE) && pany;
    ctl.hit   = ctl.lat && hit;
    ctl.issue = (st == MS_ISSUE);
    // an extack landing on the final watchdog cycle still wins
    ctl.cap   = (st == MS_WAIT) && ack_ok;
    ctl.tmo   = (st == MS_WAIT) && !ack_ok && (wd == WW'(TMO));
    ctl.fire  = (st == MS_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ack      <= '0;
      bus.rdata    <= '0;
      bus.extaddr  <= '0;
      bus.extwdata <= '0;
      bus.extwr    <= 1'b0;
      bus.extreq   <= 1'b0;
      tmoerr       <= 1'b0;
      rr           <= '0;
      idx          <= '0;
      lgnt         <= '0;
      wd           <= '0;
    end else begin
      bus.ack <= ctl.fire ? lgnt : '0;
      if (ctl.lat) begin
        idx          <= pidx;
        lgnt         <= pgnt;
        bus.extaddr  <= sel_addr;
        bus.extwdata <= sel_wd;
        bus.extwr    <= sel_wr;
      end
      if (ctl.hit) bus.rdata <= hit_data;
      if (ctl.issue) begin
        bus.extreq <= 1'b1;
        wd         <= '0;
      end else if (st == MS_WAIT) begin
        wd <= wd + 1'b1;
      end
      if (ctl.cap) begin
        bus.extreq <= 1'b0;
        if (!bus.extwr) bus.rdata <= bus.extrdata;
      end
      if (ctl.tmo) begin
        bus.extreq <= 1'b0;
        tmoerr     <= 1'b1;
        bus.rdata  <= 8'hFF;
      end
      if (ctl.fire) rr <= IW'(wrap_inc(int'(idx), N));
    end
  end

endmodule

// File: tb/tb_memsched.sv
// Directed bench for memsched: external-memory responder, ack monitor, linear steps.
module tb_memsched;
  import memsched_pkg::*;

  localparam int N = 4, AW = 22, TMO = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tmoerr;
  always #5 clk = ~clk;

  memsched_if #(.N(N), .AW(AW)) bus();
  memsched #(.N(N), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tmoerr(tmoerr)
  );

  int vectors = 0, miscompares = 0;

  // external memory responder: acks rsp_dly cycles after extreq rises
  logic       rsp_en = 1'b1;
  int         rsp_dly = 0;
  logic       force_ack = 1'b0;
  logic       rsp_ack = 1'b0;
  logic [7:0] rsp_d = 8'h00;
  int         w = 0;
  int         ext_cnt = 0;
  logic       ext_prev = 1'b0;
  int         ack_cnt = 0, bad = 0;

  assign bus.extack   = rsp_ack | force_ack;
  assign bus.extrdata = rsp_d;

  function automatic logic [7:0] mdl(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  always @(negedge clk) begin
    ext_prev <= bus.extreq;
    if (bus.extreq && !ext_prev) ext_cnt <= ext_cnt + 1;
    if (bus.extreq && rsp_en && !rsp_ack) begin
      if (w == rsp_dly) begin
        rsp_ack <= 1'b1;
        rsp_d   <= mdl(bus.extaddr);
        w       <= 0;
      end else begin
        w <= w + 1;
      end
    end else begin
      rsp_ack <= 1'b0;
      if (!bus.extreq) w <= 0;
    end
  end

  always @(negedge clk) begin
    if (!$onehot0(bus.ack) || ((|bus.ack) && bus.extreq)) bad <= bad + 1;
    if (|bus.ack) ack_cnt <= ack_cnt + 1;
  end

  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_wd;
  logic          cap_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    bus.reqwr[i]             = wr;
    bus.reqaddr[i*AW +: AW]  = a;
    bus.reqwdata[i*8 +: 8]   = d;
    bus.req[i]               = 1'b1;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output int lat);
    a   = '0;
    lat = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      lat++;
      if (bus.extreq) begin
        cap_addr = bus.extaddr;
        cap_wd   = bus.extwdata;
        cap_wr   = bus.extwr;
      end
      if (bus.ack != '0) begin
        a = bus.ack;
        break;
      end
    end
    chk("ack_seen", 32'(a != '0), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0]  a, gexp;
    logic [AW-1:0] base0;
    int            lat, lat2, e0, ac0;
    int            ord [5];

    bus.req = '0; bus.reqwr = '0; bus.reqaddr = '0; bus.reqwdata = '0;
    ord = '{0, 1, 2, 3, 0};
    base0 = 22'h002000;

    repeat (2) @(negedge clk);
    chk("rst_ack",     32'(bus.ack),     32'h0);
    chk("rst_rdata",   32'(bus.rdata),   32'h0);
    chk("rst_extaddr", 32'(bus.extaddr), 32'h0);
    chk("rst_extreq",  32'(bus.extreq),  32'h0);
    chk("rst_extwr",   32'(bus.extwr),   32'h0);
    chk("rst_tmoerr",  32'(tmoerr),      32'h0);
    reset = 1'b0;

    // single read from requester 1, extack two cycles after extreq
    rsp_dly = 2;
    e0 = ext_cnt;
    set_req(MS_CROM, 1'b0, 22'h012345, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_CROM] = 1'b0;
    chk("t1_ack",     32'(a),        32'h2);
    chk("t1_rdata",   32'(bus.rdata), 32'hA5);
    chk("t1_extaddr", 32'(cap_addr), 32'h012345);
    chk("t1_latency", 32'(lat),      32'd6);
    #2 chk("t1_extcnt", 32'(ext_cnt - e0), 32'd1);
    @(negedge clk);
    chk("t1_pulse", 32'(bus.ack), 32'h0);

    // all four held: round-robin 0,1,2,3,0
    do_reset();
    rsp_dly = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, base0 + AW'(i * 17), 8'h00);
    for (int g = 0; g < 5; g++) begin
      wait_ack(a, lat);
      gexp = N'(1) << ord[g];
      chk("t2_grant", 32'(a), 32'(gexp));
      if (g == 4) bus.req = '0;
      @(negedge clk);
      chk("t2_pulse", 32'(bus.ack), 32'h0);
    end
    chk("t2_rdata", 32'(bus.rdata), 32'(mdl(base0)));

    // write from requester 3 leaves rdata alone
    set_req(MS_CHRRAM, 1'b1, 22'h001FFF, 8'h3C);
    wait_ack(a, lat);
    bus.req[MS_CHRRAM] = 1'b0;
    chk("t3_ack",      32'(a),          32'h8);
    chk("t3_extwr",    32'(cap_wr),     32'h1);
    chk("t3_extwdata", 32'(cap_wd),     32'h3C);
    chk("t3_extaddr",  32'(cap_addr),   32'h001FFF);
    chk("t3_rdata",    32'(bus.rdata),  32'(mdl(base0)));
    chk("t3_latency",  32'(lat),        32'd4);
    bus.reqwr[MS_CHRRAM] = 1'b0;

    // extack on the last watchdog cycle is a normal completion
    rsp_dly = TMO;
    set_req(MS_PRGRAM, 1'b0, 22'h3355AA, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_PRGRAM] = 1'b0;
    chk("t4a_ack",     32'(a),         32'h4);
    chk("t4a_latency", 32'(lat),       32'd259);
    chk("t4a_rdata",   32'(bus.rdata), 32'(mdl(22'h3355AA)));
    chk("t4a_tmoerr",  32'(tmoerr),    32'h0);
    @(negedge clk);

    // extack withheld: watchdog fires
    rsp_en = 1'b0;
    set_req(MS_PRGRAM, 1'b0, 22'h0ABCDE, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_PRGRAM] = 1'b0;
    chk("t4b_ack",     32'(a),          32'h4);
    chk("t4b_latency", 32'(lat),        32'd259);
    chk("t4b_rdata",   32'(bus.rdata),  32'hFF);
    chk("t4b_tmoerr",  32'(tmoerr),     32'h1);
    chk("t4b_extreq",  32'(bus.extreq), 32'h0);
    @(negedge clk);

    // next request is served normally; tmoerr stays sticky
    rsp_en = 1'b1;
    rsp_dly = 1;
    set_req(MS_PROM, 1'b0, 22'h000777, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_PROM] = 1'b0;
    chk("t4c_ack",     32'(a),         32'h1);
    chk("t4c_rdata",   32'(bus.rdata), 32'h97);
    chk("t4c_latency", 32'(lat),       32'd5);
    chk("t4c_tmoerr",  32'(tmoerr),    32'h1);
    @(negedge clk);

    // reset while waiting on the external port, late extack afterwards
    rsp_en = 1'b0;
    set_req(MS_CROM, 1'b0, 22'h000123, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.extreq) break;
    end
    chk("t5_inwait", 32'(bus.extreq), 32'h1);
    @(negedge clk);
    #2 ac0 = ack_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_extreq_drop", 32'(bus.extreq), 32'h0);
    reset = 1'b0;
    force_ack = 1'b1;
    bus.req = '0;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("t5_no_ack",  32'(ack_cnt - ac0), 32'd0);
    chk("t5_extreq",  32'(bus.extreq),    32'h0);
    chk("t5_tmoerr",  32'(tmoerr),        32'h0);
    rsp_en = 1'b1;
    rsp_dly = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 22'h003000 + AW'(i), 8'h00);
    wait_ack(a, lat);
    bus.req = '0;
    chk("t5_rr_reset", 32'(a), 32'h1);
    @(negedge clk);

    // repeated read of 0x100, then a write, then the read again
    #2 e0 = ext_cnt;
    set_req(MS_PROM, 1'b0, 22'h000100, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_PROM] = 1'b0;
    chk("t6_lat1", 32'(lat), 32'd4);
    @(negedge clk);
    set_req(MS_PROM, 1'b0, 22'h000100, 8'h00);
    wait_ack(a, lat2);
    bus.req[MS_PROM] = 1'b0;
    chk("t6_rdata", 32'(bus.rdata), 32'hE0);
`ifdef MEMSCHED_CACHE_EN
    chk("t6_lat2",   32'(lat2), 32'd2);
    #2 chk("t6_ext", 32'(ext_cnt - e0), 32'd1);
`else
    chk("t6_lat2",   32'(lat2), 32'd4);
    #2 chk("t6_ext", 32'(ext_cnt - e0), 32'd2);
`endif
    @(negedge clk);
    set_req(MS_PRGRAM, 1'b1, 22'h000200, 8'h11);
    wait_ack(a, lat);
    bus.req[MS_PRGRAM] = 1'b0;
    bus.reqwr[MS_PRGRAM] = 1'b0;
    @(negedge clk);
    #2 e0 = ext_cnt;
    set_req(MS_PROM, 1'b0, 22'h000100, 8'h00);
    wait_ack(a, lat);
    bus.req[MS_PROM] = 1'b0;
    chk("t6_lat3",  32'(lat),       32'd4);
    chk("t6_rdata3", 32'(bus.rdata), 32'hE0);
    #2 chk("t6_ext3", 32'(ext_cnt - e0), 32'd1);

    repeat (2) @(negedge clk);
    #2 chk("ack_onehot_no_overlap", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
